datapath_demux: RTL and testbench

Registered 1-to-2 demultiplexer for the 16-bit datapath: accepts one word per cycle from an upstream producer and steers it, by a select bit, to one of two downstream consumers. It is the distribution-side counterpart of the datapath's 2:1 selection muxes: where those pick one of two sources, this block routes one source to one of two sinks. Each output has its own one-entry holding slot with a valid/ready handshake, so a stalled sink does not block traffic to the other sink. Per-output 8-bit delivery counters support debug.

---
 rtl/datapath_pkg.sv | 14 +
 rtl/demux_slot.sv | 45 ++++
 rtl/datapath_demux.sv | 82 ++++++++
 tb/tb_datapath_demux.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared constants and types for the 16-bit datapath distribution logic.
package datapath_pkg;

   localparam int unsigned DP_WIDTH = 16;

   localparam logic DEST_OUT0 = 1'b0;
   localparam logic DEST_OUT1 = 1'b1;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

endpackage : datapath_pkg

// File: rtl/demux_slot.sv
// One-entry holding slot with valid/ready handshake toward a single sink.
module demux_slot
   import datapath_pkg::*;
#(
   parameter int unsigned WIDTH = DP_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             ready_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);

   slot_state_e      state_q, state_d;
   logic [WIDTH-1:0] data_q,  data_d;

   // State and data registers, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= SLOT_EMPTY;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

   // Next state: a load always wins (covers back-to-back refill), else drain on transfer.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      if (load_i) begin
         state_d = SLOT_FULL;
         data_d  = data_i;
      end else if ((state_q == SLOT_FULL) && ready_i) begin
         state_d = SLOT_EMPTY;
      end
   end

   assign valid_o = (state_q == SLOT_FULL);
   assign data_o  = data_q;

endmodule : demux_slot

// File: rtl/datapath_demux.sv
// Registered 1-to-2 demultiplexer with independent per-destination slots and counters.
module datapath_demux
   import datapath_pkg::*;
#(
   parameter int unsigned WIDTH = DP_WIDTH,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
);

   logic             acc;
   logic             load0, load1;
   logic [CNT_W-1:0] cnt0_q, cnt0_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;

   // Selected slot can take a word if it is empty or draining this cycle.
   always_comb begin
      in_ready = 1'b0;
      if (in_sel == DEST_OUT1) in_ready = ~out1_valid | out1_ready;
      else                     in_ready = ~out0_valid | out0_ready;
   end

   assign acc   = in_valid & in_ready;
   assign load0 = acc & (in_sel == DEST_OUT0);
   assign load1 = acc & (in_sel == DEST_OUT1);

   demux_slot #(.WIDTH(WIDTH)) u_slot0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load0),
      .data_i  (in_data),
      .ready_i (out0_ready),
      .valid_o (out0_valid),
      .data_o  (out0_data)
   );

   demux_slot #(.WIDTH(WIDTH)) u_slot1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load1),
      .data_i  (in_data),
      .ready_i (out1_ready),
      .valid_o (out1_valid),
      .data_o  (out1_data)
   );

   // Delivery counters, wrapping modulo 2^CNT_W.
   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (load0) cnt0_d = cnt0_q + CNT_W'(1);
      if (load1) cnt1_d = cnt1_q + CNT_W'(1);
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign cnt0 = cnt0_q;
   assign cnt1 = cnt1_q;

endmodule : datapath_demux

// File: tb/tb_datapath_demux.sv
// Self-checking bench for datapath_demux: directed scenarios plus random traffic vs. a slot model.
module tb_datapath_demux;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] in_data;
   logic        in_sel;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out0_data, out1_data;
   logic        out0_valid, out1_valid;
   logic        out0_ready, out1_ready;
   logic [7:0]  cnt0, cnt1;

   int passed = 0;
   int total  = 0;

   // Reference model: what each destination currently holds and how many words it was sent.
   logic        m_valid [2];
   logic [15:0] m_data  [2];
   logic [7:0]  m_cnt   [2];
   logic        last_ready;

   datapath_demux dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out0_data  (out0_data),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out1_data  (out1_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .cnt0       (cnt0),
      .cnt1       (cnt1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One clock: apply inputs, check in_ready, advance the model at the edge, check outputs.
   task automatic step(input logic rst, input logic v, input logic sel,
                       input logic [15:0] d, input logic r0, input logic r1);
      logic rdy;
      logic rdy_n [2];
      rst_n = rst; in_valid = v; in_sel = sel; in_data = d;
      out0_ready = r0; out1_ready = r1;
      rdy_n[0] = r0; rdy_n[1] = r1;
      #1;
      rdy = !m_valid[sel] || rdy_n[sel];
      last_ready = rdy;
      if (rst) chk("in_ready", 32'(in_ready), 32'(rdy));
      @(posedge clk);
      if (!rst) begin
         for (int n = 0; n < 2; n++) begin
            m_valid[n] = 1'b0; m_data[n] = '0; m_cnt[n] = '0;
         end
      end else begin
         for (int n = 0; n < 2; n++) begin
            if (v && rdy && (int'(sel) == n)) begin
               m_valid[n] = 1'b1;
               m_data[n]  = d;
               m_cnt[n]   = m_cnt[n] + 8'd1;
            end else if (m_valid[n] && rdy_n[n]) begin
               m_valid[n] = 1'b0;
            end
         end
      end
      #1;
      chk("out0_valid", 32'(out0_valid), 32'(m_valid[0]));
      chk("out1_valid", 32'(out1_valid), 32'(m_valid[1]));
      if (m_valid[0]) chk("out0_data", 32'(out0_data), 32'(m_data[0]));
      if (m_valid[1]) chk("out1_data", 32'(out1_data), 32'(m_data[1]));
      chk("cnt0", 32'(cnt0), 32'(m_cnt[0]));
      chk("cnt1", 32'(cnt1), 32'(m_cnt[1]));
   endtask

   initial begin
      logic [7:0] c0_save;
      for (int n = 0; n < 2; n++) begin
         m_valid[n] = 1'b0; m_data[n] = '0; m_cnt[n] = '0;
      end
      rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
      out0_ready = 1'b0; out1_ready = 1'b0;
      @(posedge clk); #1;

      // Reset state
      step(1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
      chk("rst_out0_data", 32'(out0_data), 32'h0);
      chk("rst_out1_data", 32'(out1_data), 32'h0);

      // Single word to out0, then it drains
      step(1'b1, 1'b1, 1'b0, 16'hA5A5, 1'b1, 1'b0);
      chk("first_ready", 32'(last_ready), 32'h1);
      chk("first_data", 32'(out0_data), 32'hA5A5);
      chk("first_cnt0", 32'(cnt0), 32'h1);
      step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      chk("drain_valid", 32'(out0_valid), 32'h0);

      // Stalled out1 does not block out0
      step(1'b1, 1'b1, 1'b1, 16'h1111, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 16'h2222, 1'b1, 1'b0);
      chk("stall_ready", 32'(in_ready), 32'h0);
      chk("stall_hold", 32'(out1_data), 32'h1111);
      step(1'b1, 1'b1, 1'b0, 16'h3333, 1'b1, 1'b0);
      chk("bypass_out0", 32'(out0_data), 32'h3333);
      chk("bypass_out1", 32'(out1_data), 32'h1111);
      step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

      // Streaming 16 words to out0 with no bubbles
      c0_save = cnt0;
      for (int i = 1; i <= 16; i++) begin
         step(1'b1, 1'b1, 1'b0, 16'(i), 1'b1, 1'b0);
         chk("stream_data", 32'(out0_data), 32'(i));
      end
      chk("stream_cnt0", 32'(cnt0 - c0_save), 32'd16);

      // Back-to-back refill while draining
      step(1'b1, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 16'hBEEF, 1'b1, 1'b0);
      chk("b2b_valid", 32'(out0_valid), 32'h1);
      chk("b2b_data", 32'(out0_data), 32'hBEEF);

      // Counter wrap on out1
      step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      c0_save = cnt0;
      for (int i = 0; i < 256; i++)
         step(1'b1, 1'b1, 1'b1, 16'($urandom), 1'b1, 1'b1);
      chk("wrap_cnt1", 32'(cnt1), 32'(m_cnt[1]));
      chk("wrap_cnt0", 32'(cnt0), 32'(c0_save));

      // Random traffic
      for (int i = 0; i < 400; i++)
         step(1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom), 16'($urandom),
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));

      // Fill both slots then reset mid-operation
      step(1'b1, 1'b1, 1'b0, 16'hCAFE, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 16'hF00D, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 16'h5555, 1'b0, 1'b0);
      chk("rst2_out0_valid", 32'(out0_valid), 32'h0);
      chk("rst2_out1_valid", 32'(out1_valid), 32'h0);
      chk("rst2_out0_data", 32'(out0_data), 32'h0);
      chk("rst2_out1_data", 32'(out1_data), 32'h0);
      chk("rst2_cnt0", 32'(cnt0), 32'h0);
      chk("rst2_cnt1", 32'(cnt1), 32'h0);
      rst_n = 1'b1; in_valid = 1'b0; #1;
      chk("rst2_ready", 32'(in_ready), 32'h1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_datapath_demux
